// File: rtl/modulo_medidor_frequencia.sv
// Frequency meter: counts synchronised rising edges of sig_in over back-to-back
// gate windows of GATE_CYCLES clk cycles and publishes each count with a valid pulse.
module modulo_medidor_frequencia #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] freq_count,
  output logic                 valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int                   GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_WIDTH-1:0]   edge_cnt;
  logic                   ovf;

  logic                   synced;
  logic                   edge_det;
  logic                   win_last;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   ovf_next;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign edge_det = synced & ~prev_q;
  assign win_last = (gate_cnt == GATE_LAST);

  // Edge count including this cycle's edge; saturates and flags lost edges.
  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf;
    if (edge_det) begin
      if (edge_cnt == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = edge_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      freq_count <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= synced;
      valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= COUNT;
            busy     <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        COUNT: begin
          if (win_last) begin
            // Publish and restart with no gap, so no edge is lost between windows.
            freq_count <= cnt_next;
            overflow   <= ovf_next;
            valid      <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            if (!enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= cnt_next;
            ovf      <= ovf_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_medidor_frequencia.sv
// Directed bench for modulo_medidor_frequencia: a CNT_WIDTH=4 and a CNT_WIDTH=2
// instance share the same stimulus (GATE_CYCLES=20, SYNC_STAGES=2).
module tb_modulo_medidor_frequencia;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       sig_static;
  logic       en_sq;
  logic       sq = 1'b0;
  logic       sig_in;

  logic [3:0] freq4;
  logic       valid4, ovf4, busy4;
  logic [1:0] freq2;
  logic       valid2, ovf2, busy2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int waited;
  int last_cyc;
  int total;

  always #5 clk = ~clk;

  // clk/4 square wave: 2 clk periods high, 2 low, edges well away from clk edges.
  initial begin
    #6;
    forever begin
      sq = ~sq;
      #20;
    end
  end

  assign sig_in = en_sq ? sq : sig_static;

  always @(posedge clk) cyc <= cyc + 1;

  modulo_medidor_frequencia #(.GATE_CYCLES(20), .CNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .clr(clr), .enable(enable), .sig_in(sig_in),
    .freq_count(freq4), .valid(valid4), .overflow(ovf4), .busy(busy4)
  );

  modulo_medidor_frequencia #(.GATE_CYCLES(20), .CNT_WIDTH(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .clr(clr), .enable(enable), .sig_in(sig_in),
    .freq_count(freq2), .valid(valid2), .overflow(ovf2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (valid4 !== 1'b1 && n < 40);
    check(tag, 32'(valid4), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_freq4"}, 32'(freq4), 32'd0);
    check({tag, "_valid4"}, 32'(valid4), 32'd0);
    check({tag, "_ovf4"}, 32'(ovf4), 32'd0);
    check({tag, "_busy4"}, 32'(busy4), 32'd0);
    check({tag, "_freq2"}, 32'(freq2), 32'd0);
    check({tag, "_valid2"}, 32'(valid2), 32'd0);
    check({tag, "_ovf2"}, 32'(ovf2), 32'd0);
    check({tag, "_busy2"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    clr        = 1'b0;
    enable     = 1'b1;
    en_sq      = 1'b1;
    sig_static = 1'b0;

    // Reset held with enable and a toggling input.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("reset");
    end
    clr = 1'b1;
    check("release_busy_first", 32'(busy4), 32'd0);
    tick();
    check("release_busy4", 32'(busy4), 32'd1);
    check("release_busy2", 32'(busy2), 32'd1);
    last_cyc = cyc;

    // Five back-to-back windows of a clk/4 input: 5 edges each; 2-bit counter saturates.
    total = 0;
    for (int w = 0; w < 5; w++) begin
      wait_valid("win_valid", waited);
      check("win_period", 32'(cyc - last_cyc), 32'd20);
      last_cyc = cyc;
      check("win_freq4", 32'(freq4), 32'd5);
      check("win_ovf4", 32'(ovf4), 32'd0);
      check("win_valid2", 32'(valid2), 32'd1);
      check("win_freq2", 32'(freq2), 32'd3);
      check("win_ovf2", 32'(ovf2), 32'd1);
      total += int'(freq4);
      tick();
      check("win_valid_one_cycle", 32'(valid4), 32'd0);
      check("win_freq_hold", 32'(freq4), 32'd5);
    end
    check("total_edges", 32'(total), 32'd25);

    // Abort at cycle 10 of the next window.
    for (int i = 0; i < 8; i++) tick();
    enable = 1'b0;
    tick();
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_valid", 32'(valid4), 32'd0);
    check("abort_freq", 32'(freq4), 32'd5);
    check("abort_ovf", 32'(ovf4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_valid", 32'(valid4), 32'd0);
      check("idle_busy", 32'(busy4), 32'd0);
      check("idle_freq", 32'(freq4), 32'd5);
    end
    enable = 1'b1;
    tick();
    check("reenable_busy", 32'(busy4), 32'd1);
    last_cyc = cyc;
    wait_valid("reenable_valid", waited);
    check("reenable_period", 32'(cyc - last_cyc), 32'd20);
    check("reenable_freq4", 32'(freq4), 32'd5);
    check("reenable_ovf4", 32'(ovf4), 32'd0);
    check("reenable_freq2", 32'(freq2), 32'd3);

    // Static low input.
    enable     = 1'b0;
    en_sq      = 1'b0;
    sig_static = 1'b0;
    tick();
    check("static_abort_busy", 32'(busy4), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b1;
    tick();
    last_cyc = cyc;
    wait_valid("low_valid", waited);
    check("low_period", 32'(cyc - last_cyc), 32'd20);
    check("low_freq4", 32'(freq4), 32'd0);
    check("low_ovf4", 32'(ovf4), 32'd0);
    check("low_freq2", 32'(freq2), 32'd0);
    check("low_ovf2", 32'(ovf2), 32'd0);

    // Static high input, raised while idle so its one rise is never counted.
    enable     = 1'b0;
    sig_static = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b1;
    tick();
    last_cyc = cyc;
    wait_valid("high_valid", waited);
    check("high_period", 32'(cyc - last_cyc), 32'd20);
    check("high_freq4", 32'(freq4), 32'd0);
    check("high_ovf4", 32'(ovf4), 32'd0);
    check("high_freq2", 32'(freq2), 32'd0);

    // Reset in the middle of a window after a full window reported 5.
    en_sq = 1'b1;
    wait_valid("settle_valid", waited);
    wait_valid("pre_reset_valid", waited);
    check("pre_reset_freq4", 32'(freq4), 32'd5);
    check("pre_reset_freq2", 32'(freq2), 32'd3);
    for (int i = 0; i < 11; i++) tick();
    clr = 1'b0;
    tick();
    check_reset_outputs("midreset");
    clr = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy4), 32'd1);
    last_cyc = cyc;
    wait_valid("post_reset_valid", waited);
    check("post_reset_period", 32'(cyc - last_cyc), 32'd20);
    check("post_reset_freq4", 32'(freq4), 32'd5);
    check("post_reset_ovf4", 32'(ovf4), 32'd0);
    check("post_reset_freq2", 32'(freq2), 32'd3);
    check("post_reset_ovf2", 32'(ovf2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
